// File: rtl/iomem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared block-RAM behind the iomem bus.
// Issues one RAM strobe per granted request, waits a fixed latency, then returns a ready pulse.
module iomem_arbiter #(
    parameter int unsigned BLOCK_SIZE    = 128,
    parameter int unsigned RAM_DELAY     = 16,
    parameter logic [31:0] RAM_BASE_ADDR = 32'h4000_0000,
    parameter logic [31:0] RAM_MASK_ADDR = 32'h000F_FFFF,
    parameter int unsigned RAM_DEPTH     = 8192,
    localparam int unsigned NUMS_BYTE    = BLOCK_SIZE / 8,
    localparam int unsigned RAM_AW       = $clog2(RAM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_valid_i,
    input  logic [31:0]           m0_addr_i,
    input  logic [NUMS_BYTE-1:0]  m0_wstrb_i,
    input  logic [BLOCK_SIZE-1:0] m0_wdata_i,
    output logic                  m0_ready_o,
    output logic [BLOCK_SIZE-1:0] m0_rdata_o,
    input  logic                  m1_valid_i,
    input  logic [31:0]           m1_addr_i,
    input  logic [NUMS_BYTE-1:0]  m1_wstrb_i,
    input  logic [BLOCK_SIZE-1:0] m1_wdata_i,
    output logic                  m1_ready_o,
    output logic [BLOCK_SIZE-1:0] m1_rdata_o,
    output logic [RAM_AW-1:0]     ram_addr_o,
    output logic [BLOCK_SIZE-1:0] ram_wdata_o,
    output logic [NUMS_BYTE-1:0]  ram_wstrb_o,
    output logic                  ram_rd_en_o,
    input  logic [BLOCK_SIZE-1:0] ram_rdata_i,
    output logic [1:0]            grant_o,
    output logic                  busy_o
);

    localparam int unsigned ROW_LSB = $clog2(NUMS_BYTE);
    localparam int unsigned ROW_MSB = $clog2(RAM_DEPTH * NUMS_BYTE) - 1;
    localparam int unsigned CNT_W   = ($clog2(RAM_DELAY) > 16) ? $clog2(RAM_DELAY) : 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state,     w_state_nxt;
    logic [1:0]            r_owner,     w_owner_nxt;
    logic                  r_prio,      w_prio_nxt;
    logic [RAM_AW-1:0]     r_row,       w_row_nxt;
    logic [NUMS_BYTE-1:0]  r_wstrb,     w_wstrb_nxt;
    logic [BLOCK_SIZE-1:0] r_wdata,     w_wdata_nxt;
    logic [CNT_W-1:0]      r_cnt,       w_cnt_nxt;
    logic [BLOCK_SIZE-1:0] r_resp,      w_resp_nxt;
    logic                  r_m0_ready,  w_m0_ready_nxt;
    logic                  r_m1_ready,  w_m1_ready_nxt;
    logic [BLOCK_SIZE-1:0] r_m0_rdata,  w_m0_rdata_nxt;
    logic [BLOCK_SIZE-1:0] r_m1_rdata,  w_m1_rdata_nxt;
    logic                  r_ram_rd_en, w_ram_rd_en_nxt;
    logic [NUMS_BYTE-1:0]  r_ram_wstrb, w_ram_wstrb_nxt;
    logic [BLOCK_SIZE-1:0] r_ram_wdata, w_ram_wdata_nxt;
    logic                  r_busy,      w_busy_nxt;

    logic                  w_any;
    logic                  w_pick_m1;
    logic [31:0]           w_sel_addr;
    logic [NUMS_BYTE-1:0]  w_sel_wstrb;
    logic [BLOCK_SIZE-1:0] w_sel_wdata;
    logic                  w_hit;
    logic                  w_first_wait;

    // Round-robin pick: prio=1 favours m1 when both request
    always_comb begin
        w_any       = m0_valid_i | m1_valid_i;
        w_pick_m1   = m1_valid_i & (~m0_valid_i | r_prio);
        w_sel_addr  = w_pick_m1 ? m1_addr_i  : m0_addr_i;
        w_sel_wstrb = w_pick_m1 ? m1_wstrb_i : m0_wstrb_i;
        w_sel_wdata = w_pick_m1 ? m1_wdata_i : m0_wdata_i;
        w_hit       = ((w_sel_addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR);
        w_first_wait = (r_cnt == CNT_W'(RAM_DELAY - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_prio      <= 1'b0;
            r_row       <= '0;
            r_wstrb     <= '0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_resp      <= '0;
            r_m0_ready  <= 1'b0;
            r_m1_ready  <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
            r_ram_rd_en <= 1'b0;
            r_ram_wstrb <= '0;
            r_ram_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_prio      <= w_prio_nxt;
            r_row       <= w_row_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_wdata     <= w_wdata_nxt;
            r_cnt       <= w_cnt_nxt;
            r_resp      <= w_resp_nxt;
            r_m0_ready  <= w_m0_ready_nxt;
            r_m1_ready  <= w_m1_ready_nxt;
            r_m0_rdata  <= w_m0_rdata_nxt;
            r_m1_rdata  <= w_m1_rdata_nxt;
            r_ram_rd_en <= w_ram_rd_en_nxt;
            r_ram_wstrb <= w_ram_wstrb_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next state plus next values of every registered output
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_prio_nxt      = r_prio;
        w_row_nxt       = r_row;
        w_wstrb_nxt     = r_wstrb;
        w_wdata_nxt     = r_wdata;
        w_cnt_nxt       = r_cnt;
        w_resp_nxt      = r_resp;
        w_m0_ready_nxt  = 1'b0;
        w_m1_ready_nxt  = 1'b0;
        w_m0_rdata_nxt  = '0;
        w_m1_rdata_nxt  = '0;
        w_ram_rd_en_nxt = 1'b0;
        w_ram_wstrb_nxt = '0;
        w_ram_wdata_nxt = '0;

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_owner_nxt = w_pick_m1 ? 2'b10 : 2'b01;
                    w_row_nxt   = w_sel_addr[ROW_MSB:ROW_LSB];
                    w_wstrb_nxt = w_sel_wstrb;
                    w_wdata_nxt = w_sel_wdata;
                    w_resp_nxt  = '0;
                    if (w_hit) begin
                        w_state_nxt     = S_ISSUE;
                        w_ram_rd_en_nxt = (w_sel_wstrb == '0);
                        w_ram_wstrb_nxt = w_sel_wstrb;
                        w_ram_wdata_nxt = w_sel_wdata;
                    end else begin
                        // Out-of-region: writes dropped, reads answer zero
                        w_state_nxt    = S_RESP;
                        w_m0_ready_nxt = ~w_pick_m1;
                        w_m1_ready_nxt = w_pick_m1;
                    end
                end
            end
            S_ISSUE: begin
                w_cnt_nxt   = CNT_W'(RAM_DELAY - 1);
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_first_wait && (r_wstrb == '0)) begin
                    w_resp_nxt = ram_rdata_i;
                end
                if (r_cnt == '0) begin
                    w_state_nxt    = S_RESP;
                    w_m0_ready_nxt = r_owner[0];
                    w_m1_ready_nxt = r_owner[1];
                    w_m0_rdata_nxt = r_owner[0] ? w_resp_nxt : '0;
                    w_m1_rdata_nxt = r_owner[1] ? w_resp_nxt : '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                w_prio_nxt  = r_owner[0];
                w_owner_nxt = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_owner_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign m0_ready_o  = r_m0_ready;
    assign m1_ready_o  = r_m1_ready;
    assign m0_rdata_o  = r_m0_rdata;
    assign m1_rdata_o  = r_m1_rdata;
    assign ram_addr_o  = r_row;
    assign ram_wdata_o = r_ram_wdata;
    assign ram_wstrb_o = r_ram_wstrb;
    assign ram_rd_en_o = r_ram_rd_en;
    assign grant_o     = r_owner;
    assign busy_o      = r_busy;

endmodule

// File: doc/iomem_arbiter.md
# iomem_arbiter

Two-port round-robin arbiter and sequencer for the shared 128-bit block-RAM main memory behind the SoC `iomem` bus. It accepts block requests from two requesters, such as the CPU port and the UART program loader. It issues exactly one RAM read or write strobe per granted request and enforces a fixed, parameterised RAM response latency. It returns a single-cycle ready pulse with registered read data to the granted requester.

## Interface
Parameters:
- `BLOCK_SIZE`, 128: data width in bits; `NUMS_BYTE = BLOCK_SIZE/8` strobe bits.
- `RAM_DELAY`, 16: wait cycles inserted between the RAM strobe and the response; legal range ≥1.
- `RAM_BASE_ADDR`, 32'h4000_0000: RAM region base.
- `RAM_MASK_ADDR`, 32'h000F_FFFF: RAM region mask. An address hits when `(addr & ~RAM_MASK_ADDR) == RAM_BASE_ADDR`.
- `RAM_DEPTH`, 8192: RAM rows. `ram_addr_o` is `addr[$clog2(RAM_DEPTH*NUMS_BYTE)-1 : $clog2(NUMS_BYTE)]`.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `m0_valid_i` / `m1_valid_i` in 1: request pending; held until the matching ready.
- `m0_addr_i` / `m1_addr_i` in 32: byte address; must be stable while valid.
- `m0_wstrb_i` / `m1_wstrb_i` in NUMS_BYTE: byte write strobes; all-zero means read.
- `m0_wdata_i` / `m1_wdata_i` in BLOCK_SIZE: write data.
- `m0_ready_o` / `m1_ready_o` out 1: one-cycle completion pulse.
- `m0_rdata_o` / `m1_rdata_o` out BLOCK_SIZE: read data, valid only while the matching ready is high; zero otherwise.
- `ram_addr_o` out $clog2(RAM_DEPTH): RAM row address.
- `ram_wdata_o` out BLOCK_SIZE: RAM write data.
- `ram_wstrb_o` out NUMS_BYTE: RAM byte enables; nonzero only in ISSUE.
- `ram_rd_en_o` out 1: RAM read enable; high only in ISSUE.
- `ram_rdata_i` in BLOCK_SIZE: RAM read data, registered, valid the cycle after `ram_rd_en_o`.
- `grant_o` out 2: one-hot current owner; 2'b00 when idle.
- `busy_o` out 1: high when the state is not IDLE.

## Operation
- FSM states are IDLE, ISSUE, WAIT, RESP. A 2-bit registered owner and a 1-bit priority pointer `prio` accompany the FSM.
- IDLE:
  - If any valid is high, grant one requester: `prio` selects when both are valid, otherwise the sole requester wins.
  - Latch the owner's addr, wstrb and wdata.
  - Go to ISSUE on a RAM-region hit; otherwise go directly to RESP.
- ISSUE (1 cycle):
  - Drive `ram_addr_o` and `ram_wdata_o`.
  - Drive `ram_wstrb_o` with the latched wstrb, or `ram_rd_en_o=1` when the latched wstrb is zero.
  - Load the wait counter with `RAM_DELAY-1` and go to WAIT.
- WAIT:
  - In the first WAIT cycle, capture `ram_rdata_i` into the response register on reads.
  - Decrement the counter; on count 0 go to RESP. WAIT therefore lasts exactly RAM_DELAY cycles.
- RESP (1 cycle):
  - Assert the owner's ready and present the response register on the owner's rdata.
  - Set `prio` to the non-owner and go to IDLE.
- Out-of-region accesses:
  - No RAM strobe is issued.
  - Writes are dropped.
  - Reads return all-zero data.
- All RAM outputs are zero whenever the state is not ISSUE, except `ram_addr_o`, which holds the latched value.
- The non-owner's valid is ignored until the arbiter returns to IDLE; no request is lost and none is granted twice.

## Timing
- Reset values (async, immediate): state IDLE, `prio`=m0, owner none, counter 0, response register 0. All `*_ready_o`, `*_rdata_o`, `ram_*_o`, `grant_o` and `busy_o` are 0.
- The accept cycle is the cycle in IDLE with valid high.
- RAM-hit latency: ready is high exactly RAM_DELAY+2 cycles after the accept cycle.
- Out-of-region latency: ready is high 1 cycle after the accept cycle.
- After RESP the arbiter is in IDLE for 1 cycle. A requester that keeps valid high after its ready is treated as issuing a new request, and that request competes in IDLE.
- Back-to-back throughput for RAM hits is one request per RAM_DELAY+3 cycles.
- `grant_o` is registered and is valid from the cycle after accept through RESP.
- Reset mid-transaction: the transaction is aborted, no ready pulse is issued, and any strobe is cut immediately. Requesters must reissue.
- The counter must cover RAM_DELAY up to at least 65535 without wrap.

## Test plan
- Single m0 read, RAM_DELAY=4, addr 32'h4000_0010:
  - `ram_rd_en_o` pulses for 1 cycle with `ram_addr_o`=1.
  - `m0_ready_o` pulses 6 cycles after accept, with `m0_rdata_o` equal to the RAM row 1 contents.
- m1 write, wstrb 16'h000F, data 32'hDEADBEEF in the low word, addr 32'h4000_0020:
  - `ram_wstrb_o`=16'h000F for exactly 1 cycle, `ram_addr_o`=2.
  - A readback from m0 returns 32'hDEADBEEF in the low word.
- Both valid continuously from reset:
  - The grant order is m0, m1, m0, m1.
  - Each ready arrives exactly once per grant, and `grant_o` is one-hot during every transaction.
- Out-of-region read at 32'h2000_0000:
  - No RAM strobe is issued.
  - `m0_ready_o` pulses 1 cycle after accept with rdata 0.
- Assert `rst_i` during WAIT of an m0 read:
  - All outputs are 0 in the same cycle and no ready pulse occurs.
  - After release with m1 valid, m1 is served after m0-priority evaluation (m0 idle).
- RAM_DELAY=1 boundary:
  - Ready occurs at accept+3.
  - Read data is captured correctly from the first WAIT cycle.
